fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that replaces the externally driven program counter of CPU_V1. It owns the PC, issues sequential requests to a synchronous instruction memory with one-cycle read latency, and buffers the returned words with their PCs in a DEPTH-entry FIFO. A valid/ready handshake delivers them to decode. A redirect input (branch/jump) reloads the PC and squashes every buffered and in-flight instruction.

---
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues 1-cycle-latency imem reads, buffers {instr, pc} in a DEPTH-entry FIFO.
// Request to out_valid is 2 cycles; requests stall while the FIFO plus the in-flight read would overflow.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [ADDR_WIDTH-1:0]        imem_addr,
    input  logic [DATA_WIDTH-1:0]        imem_data,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_instr,
    output logic [ADDR_WIDTH-1:0]        out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]      DEPTH_L = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP_L = ADDR_WIDTH'(PC_STEP);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    entry_t                fifo_mem [DEPTH];
    entry_t                head;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  pop;
    logic                  push;
    logic [CNT_W:0]        occupancy;

    // Occupancy counts the read already in flight, so a returning word always has a slot.
    assign occupancy = {1'b0, count}
                     + {{CNT_W{1'b0}}, inflight}
                     - {{CNT_W{1'b0}}, pop};

    assign out_valid = (count != '0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign push      = inflight & ~redirect_valid;
    assign imem_req  = reset & ~redirect_valid & (occupancy < DEPTH_L);
    assign imem_addr = pc;

    assign head      = fifo_mem[rd_ptr];
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            // Flush everything; the response to any in-flight read is dropped by clearing inflight.
            pc       <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (imem_req) begin
                pc          <= pc + STEP_L;
                inflight    <= 1'b1;
                inflight_pc <= pc;
            end else begin
                inflight <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{instr: imem_data, pc: inflight_pc};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences, a 1-cycle memory model, and an in-order PC scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'hDEAD_BEEF;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pop   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    fetch_unit #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Synchronous instruction memory; unrequested cycles return junk so stale captures show up.
    always @(posedge clk) begin
        imem_data <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic new_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 128; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got pc %h with nothing expected", out_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("out_pc", out_pc, mon_exp);
                chk("out_instr", out_instr, mem_word(mon_exp));
            end
        end
    end

    // Leaves the caller at cycle C0, just after reset release.
    task automatic reset_seq(input logic rdy);
        @(posedge clk); #1;
        reset = 1'b0;
        redirect_valid = 1'b0;
        out_ready = rdy;
        new_stream(32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        int nreq;
        int base;

        // Reset state and streaming with out_ready high
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        new_stream(32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_req", 32'(imem_req), 32'd1);
            chk("t1_addr", imem_addr, 32'(4 * i));
            chk("t1_valid", 32'(out_valid), 32'(i >= 2));
        end
        repeat (20) @(posedge clk);

        // Backpressure: fill to DEPTH, then release
        reset_seq(1'b0);
        nreq = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (imem_req) begin
                chk("t2_addr", imem_addr, 32'(4 * nreq));
                nreq++;
            end
        end
        chk("t2_nreq", 32'(nreq), 32'd4);
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_req_full", 32'(imem_req), 32'd0);
        chk("t2_pc_hold", imem_addr, 32'd16);
        @(posedge clk); #1;
        base = n_pop;
        out_ready = 1'b1;
        #1;
        chk("t2_req_same_cycle", 32'(imem_req), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        chk("t2_delivered", 32'(n_pop - base), 32'd12);

        // Redirect with count 3 and a read in flight
        reset_seq(1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_count3", 32'(count), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        out_ready = 1'b1;
        new_stream(32'h100);
        @(negedge clk);
        chk("t3_valid_redir", 32'(out_valid), 32'd0);
        chk("t3_req_redir", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        chk("t3_count_flush", 32'(count), 32'd0);
        @(negedge clk);
        chk("t3_req_r1", 32'(imem_req), 32'd1);
        chk("t3_addr_r1", imem_addr, 32'h100);
        @(negedge clk);
        chk("t3_valid_r2", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t3_valid_r3", 32'(out_valid), 32'd1);
        repeat (8) @(posedge clk);

        // Redirect coinciding with out_ready, count 2
        reset_seq(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_count2", 32'(count), 32'd2);
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        new_stream(32'h200);
        #1;
        chk("t4_valid_redir", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        chk("t4_count_flush", 32'(count), 32'd0);
        repeat (6) @(posedge clk);

        // Asynchronous reset pulse mid-stream with count 2
        reset_seq(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_count2", 32'(count), 32'd2);
        reset = 1'b0;
        new_stream(32'h0);
        #1;
        chk("t5_count_async", 32'(count), 32'd0);
        chk("t5_valid_async", 32'(out_valid), 32'd0);
        chk("t5_req_async", 32'(imem_req), 32'd0);
        chk("t5_addr_async", imem_addr, 32'h0);
        out_ready = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("t5_req_restart", 32'(imem_req), 32'd1);
        chk("t5_addr_restart", imem_addr, 32'h0);
        repeat (8) @(posedge clk);

        // PC wrap at the top of the address space with random backpressure
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        new_stream(32'hFFFF_FFF8);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        base = n_pop;
        for (int c = 0; c < 90; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t6_enough_delivered", 32'((n_pop - base) >= 24), 32'd1);

        reset = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
